bram_burst_arbiter: RTL
=======================

Name: bram_burst_arbiter

Overview:
- Round-robin arbiter and burst sequencer for one bram read port in the cifar-mlp datapath.
- NUM_REQ requesters (layer engines, activation readers, debug dump) each post a base address and a word count.
- The block grants one requester at a time and issues consecutive single-cycle reads to the bram.
- It returns each word tagged with the winner's ID, then pulses done.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, bram word width.
- ADDR_WIDTH, 10, bram address width.
- LEN_WIDTH, 8, burst length field width (max burst 2^LEN_WIDTH-1 words).
- ID_WIDTH, $clog2(NUM_REQ) (min 1), requester ID width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester burst request level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed base addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths, same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse; request accepted.
- busy  out  1  high from grant through the last issued read.
- bram_rden  out  1  bram read enable.
- bram_rdaddr  out  ADDR_WIDTH  bram read address.
- bram_q  in  DATA_WIDTH  bram read data; valid one cycle after rden.
- rd_valid  out  1  rd_data/rd_id valid this cycle.
- rd_data  out  DATA_WIDTH  equals bram_q (combinational pass-through).
- rd_id  out  ID_WIDTH  ID of the requester owning rd_data.
- done  out  NUM_REQ  one-hot, one-cycle pulse coinciding with the last rd_valid of a burst.

Behaviour:
- Reset (async): FSM=IDLE, gnt=0, busy=0, bram_rden=0, bram_rdaddr=0, rd_valid=0, rd_id=0, done=0, rr_ptr=0.
- FSM states: IDLE and BURST.
- IDLE, at least one req high:
  - Winner is the first set req bit searching upward from rr_ptr, wrapping around.
  - At the clock edge: latch cur_addr=req_addr[winner], remaining=req_len[winner] and owner=winner; pulse gnt[winner] for the following cycle.
  - rr_ptr becomes (winner+1) mod NUM_REQ; go to BURST.
- IDLE, no req high: stay in IDLE; outputs idle.
- BURST, per cycle while remaining!=0:
  - Drive bram_rden=1 and bram_rdaddr=cur_addr.
  - Then cur_addr+=1, wrapping modulo 2^ADDR_WIDTH; remaining-=1.
  - When remaining reaches 0 after an issue, return to IDLE.
- The first read issues in the same cycle gnt is high. Throughput is 1 word/cycle.
- bram_rden, bram_rdaddr, busy and gnt are registered (glitch-free).
- rd_valid and rd_id are the issue strobe and owner delayed one register stage, aligned with bram_q.
- done[owner] asserts with rd_valid on the final word.
- Burst of length L: gnt in cycle G, reads issued in cycles G..G+L-1, rd_valid in cycles G+1..G+L, done in cycle G+L.
- len=0: grant still pulses, no read is issued, done[owner] pulses in the cycle after gnt with rd_valid=0, then back to IDLE.
- Back-to-back bursts: one IDLE cycle separates the last issue of one burst from the next grant. Arbitration happens in that IDLE cycle.
- Request rules:
  - Requesters hold req, addr and len stable until gnt.
  - Dropping req before gnt withdraws the request without side effects.
  - req held high after gnt is a new request.
- A new request from the current owner during BURST is not granted until IDLE; round-robin then favours the others.
- Reset mid-burst:
  - Immediate return to IDLE with all outputs 0.
  - The in-flight bram word is discarded: no rd_valid, no done after reset.
- Write port of the bram is not touched by this block.

Test Plan:
- Single burst: req[1]=1, addr=0x010, len=3 → gnt[1] in cycle G.
  - bram_rdaddr 0x010, 0x011, 0x012 in cycles G..G+2.
  - rd_valid in G+1..G+3 with rd_id=1 and data=mem[0x010..0x012].
  - done[1] in cycle G+3.
- Round-robin fairness: req=4'b1111 held, all len=1.
  - Grant order 0,1,2,3,0.
  - Exactly one IDLE cycle between consecutive grants.
- Address wrap: addr=0x3FE, len=4, ADDR_WIDTH=10 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero length: req[2]=1, len=0 → gnt[2], no bram_rden, done[2] one cycle later, rd_valid stays 0.
- Contention during burst:
  - req[0] len=5 granted; req[3] rises mid-burst.
  - req[3] is granted only after req[0]'s fifth issue plus one IDLE cycle.
  - rd_id changes from 0 to 3 without overlap.
- Reset mid-burst: assert rst during the third read of a len=8 burst.
  - All outputs 0 immediately; no further rd_valid.
  - After release, the next grant goes to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/bram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// bram_burst_arbiter
//
// Round-robin arbiter and burst sequencer in front of a single bram read port.
// Each requester posts a base address and a word count. One requester is
// granted at a time, and the block issues one read per cycle for that
// requester. Each returned word is tagged with the owner's ID, and a one-hot
// done pulse marks the last word of the burst.
//
// Handshake: a requester raises req[i] with req_addr/req_len stable and keeps
// them stable until it sees gnt[i]. The request is consumed in the cycle
// gnt[i] is high. Dropping req before gnt withdraws the request. A req still
// high after gnt counts as a new request.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req           per-requester request level
//   req_addr      packed base addresses, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len       packed burst lengths, slice i = [i*LEN_WIDTH +: LEN_WIDTH]
//   gnt           one-hot single-cycle grant pulse (registered)
//   busy          high from the grant cycle through the last issued read
//   bram_rden     bram read enable (registered)
//   bram_rdaddr   bram read address (registered)
//   bram_q        bram read data, valid one cycle after bram_rden
//   rd_valid      rd_data/rd_id valid
//   rd_data       combinational pass-through of bram_q
//   rd_id         owner of rd_data
//   done          one-hot pulse with the final rd_valid of a burst
//                 (for zero-length bursts: the cycle after gnt)
// -----------------------------------------------------------------------------
module bram_burst_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic                          bram_rden,
    output logic [ADDR_WIDTH-1:0]         bram_rdaddr,
    input  logic [DATA_WIDTH-1:0]         bram_q,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [ID_WIDTH-1:0]           rd_id,
    output logic [NUM_REQ-1:0]            done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_WIDTH-1:0]   owner, owner_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
    logic [NUM_REQ-1:0]    gnt_nxt, done_nxt;
    logic                  busy_nxt, rden_nxt;
    logic [ADDR_WIDTH-1:0] rdaddr_nxt;

    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [LEN_WIDTH-1:0]  win_len;

    // Round-robin search: first set req bit at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    assign win_addr = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len  = req_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic. All outputs are produced one cycle
    // ahead and registered. The grant edge therefore also launches the first
    // read, which lands in the same cycle as gnt.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        owner_nxt     = owner;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        gnt_nxt       = '0;
        done_nxt      = '0;
        busy_nxt      = 1'b0;
        rden_nxt      = 1'b0;
        rdaddr_nxt    = bram_rdaddr;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_nxt  = winner;
                    gnt_nxt    = NUM_REQ'(1) << winner;
                    rr_ptr_nxt = (int'(winner) == NUM_REQ - 1) ? '0
                                                               : winner + ID_WIDTH'(1);
                    busy_nxt   = 1'b1;
                    state_nxt  = BURST;
                    if (win_len != '0) begin
                        rden_nxt      = 1'b1;
                        rdaddr_nxt    = win_addr;
                        cur_addr_nxt  = win_addr + ADDR_WIDTH'(1);
                        remaining_nxt = win_len - LEN_WIDTH'(1);
                    end else begin
                        // Zero-length burst: spend the grant cycle in BURST
                        // with nothing to issue, so done follows one cycle later.
                        remaining_nxt = '0;
                    end
                end
            end
            BURST: begin
                if (remaining != '0) begin
                    rden_nxt      = 1'b1;
                    rdaddr_nxt    = cur_addr;
                    cur_addr_nxt  = cur_addr + ADDR_WIDTH'(1);
                    remaining_nxt = remaining - LEN_WIDTH'(1);
                    busy_nxt      = 1'b1;
                end else begin
                    // The last read (if any) is issuing now. Its data returns
                    // next cycle, together with done.
                    done_nxt  = NUM_REQ'(1) << owner;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            owner       <= '0;
            cur_addr    <= '0;
            remaining   <= '0;
            gnt         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            bram_rden   <= 1'b0;
            bram_rdaddr <= '0;
            rd_valid    <= 1'b0;
            rd_id       <= '0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            owner       <= owner_nxt;
            cur_addr    <= cur_addr_nxt;
            remaining   <= remaining_nxt;
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            busy        <= busy_nxt;
            bram_rden   <= rden_nxt;
            bram_rdaddr <= rdaddr_nxt;
            // One stage behind the issue strobe, aligned with bram_q.
            rd_valid    <= bram_rden;
            rd_id       <= owner;
        end
    end

    assign rd_data = bram_q;

endmodule
